rob_ring: RTL and testbench

Parametrised reorder buffer sitting between rename/dispatch and retirement in the out-of-order RISC-V core. It allocates one entry per renamed instruction in program order and records writeback completion out of order. It retires completed entries in order, returning pd_old to the free list. It also squashes all entries younger than a mispredicted instruction. Depth, physical-register width and PC width are generics, replacing the fixed 5-bit-index entry record.

---
 rtl/rob_ring.sv | 194 +++++++++++++++++++
 tb/tb_rob_ring.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ring.sv
`default_nettype none
// ============================================================================
// Module   : rob_ring
// Purpose  : Parametrised reorder buffer. Allocates one entry per renamed
//            instruction in program order, records writeback completion out
//            of order, retires completed entries in order from the head and
//            optionally squashes everything younger than a mispredicted
//            instruction.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH   number of entries (power of two, >= 4)
//   PREG_W  physical register index width
//   PC_W    PC width
//   TAG_W   entry index width, derived as $clog2(DEPTH)
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   alloc_valid/ready/tag           rename handshake, tag = current tail
//   alloc_pd_new/pd_old/pc          payload of the allocated instruction
//   wb_valid/wb_tag                 writeback completion of one entry
//   commit_valid/ready              retirement handshake on the head entry
//   commit_pd_new/pd_old/pc/tag     head entry contents (combinational)
//   flush_valid/flush_tag           mispredict recovery (keeps flush_tag)
//   full, empty, count              occupancy status
// Configuration
//   ROB_FLUSH_EN  when defined, flush squash logic is built; otherwise the
//                 flush ports are present but ignored.
// ============================================================================
module rob_ring #(
    parameter  int DEPTH  = 16,
    parameter  int PREG_W = 8,
    parameter  int PC_W   = 32,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    input  logic [PC_W-1:0]   alloc_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [PREG_W-1:0] commit_pd_old,
    output logic [PC_W-1:0]   commit_pc,
    output logic [TAG_W-1:0]  commit_tag,
    input  logic              flush_valid,
    input  logic [TAG_W-1:0]  flush_tag,
    output logic              full,
    output logic              empty,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W-1:0] c_tag_one   = {{(TAG_W-1){1'b0}}, 1'b1};
    localparam logic [TAG_W:0]   c_cnt_one   = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [TAG_W:0]   c_cnt_depth = (TAG_W+1)'(DEPTH);

    // Entry state and pointers
    logic [DEPTH-1:0]  valid_q,    valid_d;
    logic [DEPTH-1:0]  complete_q, complete_d;
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_new_d [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [PREG_W-1:0] pd_old_d [DEPTH];
    logic [PC_W-1:0]   pc_q     [DEPTH];
    logic [PC_W-1:0]   pc_d     [DEPTH];
    logic [TAG_W-1:0]  head_q,  head_d;
    logic [TAG_W-1:0]  tail_q,  tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic w_full;
    logic w_flush_acc;
    logic w_alloc_fire;
    logic w_commit_valid;
    logic w_commit_fire;
    logic w_wb_fire;

    assign w_full = (count_q == c_cnt_depth);

`ifdef ROB_FLUSH_EN
    // Distance of the mispredicting entry from the head; every valid entry
    // further from the head than this is younger and gets squashed.
    logic [TAG_W-1:0] w_flush_age;
    assign w_flush_acc = flush_valid && valid_q[flush_tag];
    assign w_flush_age = flush_tag - head_q;
`else
    logic w_flush_unused;
    assign w_flush_acc    = 1'b0;
    assign w_flush_unused = &{1'b0, flush_valid, flush_tag};
`endif

    assign alloc_ready    = !w_full && !w_flush_acc;
    assign alloc_tag      = tail_q;
    assign w_alloc_fire   = alloc_valid && alloc_ready;
    assign w_commit_valid = valid_q[head_q] && complete_q[head_q];
    assign w_commit_fire  = w_commit_valid && commit_ready;
    assign w_wb_fire      = wb_valid && valid_q[wb_tag];

    assign commit_valid  = w_commit_valid;
    assign commit_pd_new = pd_new_q[head_q];
    assign commit_pd_old = pd_old_q[head_q];
    assign commit_pc     = pc_q[head_q];
    assign commit_tag    = head_q;
    assign full          = w_full;
    assign empty         = (count_q == '0);
    assign count         = count_q;

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        pd_new_d   = pd_new_q;
        pd_old_d   = pd_old_q;
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        // Writeback first so that a squash below can cancel it.
        if (w_wb_fire) begin
            complete_d[wb_tag] = 1'b1;
        end

        if (w_commit_fire) begin
            valid_d[head_q]    = 1'b0;
            complete_d[head_q] = 1'b0;
            head_d             = head_q + c_tag_one;
        end

`ifdef ROB_FLUSH_EN
        if (w_flush_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((TAG_W'(i) - head_q) > w_flush_age) begin
                    valid_d[i]    = 1'b0;
                    complete_d[i] = 1'b0;
                end
            end
            tail_d = flush_tag + c_tag_one;
        end
`endif

        // Allocation never coincides with an accepted flush.
        if (w_alloc_fire) begin
            valid_d[tail_q]    = 1'b1;
            complete_d[tail_q] = 1'b0;
            pd_new_d[tail_q]   = alloc_pd_new;
            pd_old_d[tail_q]   = alloc_pd_old;
            pc_d[tail_q]       = alloc_pc;
            tail_d             = tail_q + c_tag_one;
        end

`ifdef ROB_FLUSH_EN
        if (w_flush_acc) begin
            count_d = {1'b0, w_flush_age} + c_cnt_one;
            if (w_commit_fire) begin
                count_d = count_d - c_cnt_one;
            end
        end else
`endif
        if (w_alloc_fire && !w_commit_fire) begin
            count_d = count_q + c_cnt_one;
        end else if (w_commit_fire && !w_alloc_fire) begin
            count_d = count_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload is only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        pd_new_q <= pd_new_d;
        pd_old_q <= pd_old_d;
        pc_q     <= pc_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_ring
// Purpose  : Self-checking bench for rob_ring (DEPTH=16). Directed vector
//            table, hand-written corner sequences and a randomized run
//            compared against a queue-based program-order model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rob_ring;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 8;
    localparam int PC_W   = 32;
    localparam int TAG_W  = 4;
`ifdef ROB_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [PREG_W-1:0] alloc_pd_new;
    logic [PREG_W-1:0] alloc_pd_old;
    logic [PC_W-1:0]   alloc_pc;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic              commit_valid;
    logic              commit_ready;
    logic [PREG_W-1:0] commit_pd_new;
    logic [PREG_W-1:0] commit_pd_old;
    logic [PC_W-1:0]   commit_pc;
    logic [TAG_W-1:0]  commit_tag;
    logic              flush_valid;
    logic [TAG_W-1:0]  flush_tag;
    logic              full;
    logic              empty;
    logic [TAG_W:0]    count;

    rob_ring #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pd_new(commit_pd_new), .commit_pd_old(commit_pd_old),
        .commit_pc(commit_pc), .commit_tag(commit_tag),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: program-ordered queue ----------------
    typedef struct {
        logic [PREG_W-1:0] pn;
        logic [PREG_W-1:0] po;
        logic [PC_W-1:0]   pc;
        int                tag;
        bit                comp;
    } ent_t;

    ent_t q[$];
    int   m_head = 0;

    function automatic int find_pos(input int tag);
        for (int i = 0; i < q.size(); i++)
            if (q[i].tag == tag) return i;
        return -1;
    endfunction

    function automatic bit m_flush_acc();
        return FLUSH_EN && flush_valid && (find_pos(int'(flush_tag)) >= 0);
    endfunction

    function automatic bit m_commit_valid();
        if (q.size() == 0) return 1'b0;
        return q[0].comp;
    endfunction

    task automatic model_check();
        int cnt;
        cnt = q.size();
        chk("count", 64'(count), 64'(cnt));
        chk("full", 64'(full), 64'(cnt == DEPTH));
        chk("empty", 64'(empty), 64'(cnt == 0));
        chk("alloc_ready", 64'(alloc_ready), 64'((cnt != DEPTH) && !m_flush_acc()));
        chk("alloc_tag", 64'(alloc_tag), 64'((m_head + cnt) % DEPTH));
        chk("commit_valid", 64'(commit_valid), 64'(m_commit_valid()));
        if (m_commit_valid()) begin
            chk("commit_tag", 64'(commit_tag), 64'(m_head));
            chk("commit_pd_new", 64'(commit_pd_new), 64'(q[0].pn));
            chk("commit_pd_old", 64'(commit_pd_old), 64'(q[0].po));
            chk("commit_pc", 64'(commit_pc), 64'(q[0].pc));
        end
    endtask

    task automatic model_update();
        bit   cfire, afire;
        int   fpos, p, old_tail;
        ent_t e;
        if (reset) begin
            q.delete();
            m_head = 0;
            return;
        end
        cfire    = m_commit_valid() && commit_ready;
        afire    = alloc_valid && (q.size() != DEPTH) && !m_flush_acc();
        fpos     = m_flush_acc() ? find_pos(int'(flush_tag)) : -1;
        old_tail = (m_head + q.size()) % DEPTH;
        if (wb_valid) begin
            p = find_pos(int'(wb_tag));
            if (p >= 0) begin
                e = q[p]; e.comp = 1'b1; q[p] = e;
            end
        end
        if (fpos >= 0)
            while (q.size() > fpos + 1) void'(q.pop_back());
        if (cfire) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (afire) begin
            e.pn = alloc_pd_new; e.po = alloc_pd_old; e.pc = alloc_pc;
            e.tag = old_tail; e.comp = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        finish_cycle();
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_pd_new = '0; alloc_pd_old = '0; alloc_pc = '0;
        wb_valid = 1'b0; wb_tag = '0; commit_ready = 1'b0;
        flush_valid = 1'b0; flush_tag = '0;
    endtask

    task automatic set_alloc();
        alloc_valid  = 1'b1;
        alloc_pd_new = PREG_W'($urandom);
        alloc_pd_old = PREG_W'($urandom);
        alloc_pc     = PC_W'($urandom);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit                av;
        logic [PREG_W-1:0] pn;
        logic [PREG_W-1:0] po;
        logic [PC_W-1:0]   pc;
        bit                wv;
        logic [TAG_W-1:0]  wt;
        bit                cr;
        logic [TAG_W-1:0]  e_atag;
        bit                e_cv;
        logic [TAG_W-1:0]  e_ctag;
        logic [PREG_W-1:0] e_po;
        logic [TAG_W:0]    e_cnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Out-of-order writeback, in-order retirement of tags 0,1,2.
        tbl[0]  = '{1'b1, 8'h10, 8'h20, 32'h100, 1'b0, 4'd0, 1'b0, 4'd3 - 4'd3, 1'b0, 4'd0, 8'h00, 5'd0};
        tbl[1]  = '{1'b1, 8'h11, 8'h21, 32'h104, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 4'd0, 8'h00, 5'd1};
        tbl[2]  = '{1'b1, 8'h12, 8'h22, 32'h108, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 4'd0, 8'h00, 5'd2};
        tbl[3]  = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b1, 4'd2, 1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 5'd3};
        tbl[4]  = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b1, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 5'd3};
        tbl[5]  = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd0, 8'h20, 5'd3};
        tbl[6]  = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 5'd2};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b1, 4'd1, 1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 5'd2};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd1, 8'h21, 5'd2};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd2, 8'h22, 5'd1};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 32'h0,   1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 4'd0, 8'h00, 5'd0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_head = 0;

        // Reset state
        settle();
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        finish_cycle();

        for (int i = 0; i < 11; i++) begin
            idle_inputs();
            alloc_valid = tbl[i].av; alloc_pd_new = tbl[i].pn;
            alloc_pd_old = tbl[i].po; alloc_pc = tbl[i].pc;
            wb_valid = tbl[i].wv; wb_tag = tbl[i].wt; commit_ready = tbl[i].cr;
            settle();
            chk("tbl_alloc_tag", 64'(alloc_tag), 64'(tbl[i].e_atag));
            chk("tbl_commit_valid", 64'(commit_valid), 64'(tbl[i].e_cv));
            chk("tbl_count", 64'(count), 64'(tbl[i].e_cnt));
            if (tbl[i].e_cv) begin
                chk("tbl_commit_tag", 64'(commit_tag), 64'(tbl[i].e_ctag));
                chk("tbl_commit_pd_old", 64'(commit_pd_old), 64'(tbl[i].e_po));
            end
            finish_cycle();
        end

        // Fill to DEPTH: tags 0..15, then full blocks the 17th allocate.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc();
            settle();
            chk("fill_alloc_tag", 64'(alloc_tag), 64'(i));
            finish_cycle();
        end
        set_alloc();
        settle();
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("fill_count", 64'(count), 64'd16);
        finish_cycle();

        // Full + commit + allocate in the same cycle: only the commit fires.
        idle_inputs();
        wb_valid = 1'b1; wb_tag = 4'd0;
        step();
        idle_inputs();
        set_alloc();
        commit_ready = 1'b1;
        settle();
        chk("fullc_commit_valid", 64'(commit_valid), 64'd1);
        finish_cycle();
        idle_inputs();
        settle();
        chk("fullc_count", 64'(count), 64'd15);
        chk("fullc_alloc_tag", 64'(alloc_tag), 64'd0);
        finish_cycle();

        // Reset with 6 pending entries, 3 complete.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc();
            step();
        end
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            wb_valid = 1'b1; wb_tag = TAG_W'(2 * i);
            step();
        end
        idle_inputs();
        set_alloc();
        commit_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        settle();
        chk("mrst_commit_valid", 64'(commit_valid), 64'd0);
        chk("mrst_empty", 64'(empty), 64'd1);
        chk("mrst_alloc_tag", 64'(alloc_tag), 64'd0);
        finish_cycle();

        // Wrap: 20 instructions pipelined through the ring.
        do_reset();
        for (int k = 0; k < 22; k++) begin
            idle_inputs();
            if (k < 20) set_alloc();
            if (k >= 1 && k <= 20) begin
                wb_valid = 1'b1; wb_tag = TAG_W'((k - 1) % DEPTH);
            end
            commit_ready = 1'b1;
            settle();
            if (k < 20) chk("wrap_alloc_tag", 64'(alloc_tag), 64'(k % DEPTH));
            finish_cycle();
        end
        idle_inputs();
        settle();
        chk("wrap_empty", 64'(empty), 64'd1);
        finish_cycle();

        // Flush at tag 4 with entries 0..9 outstanding.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_alloc();
            step();
        end
        idle_inputs();
        flush_valid = 1'b1; flush_tag = 4'd4;
        settle();
        chk("flush_alloc_ready", 64'(alloc_ready), 64'(!FLUSH_EN));
        finish_cycle();
        idle_inputs();
        settle();
        chk("flush_alloc_tag", 64'(alloc_tag), FLUSH_EN ? 64'd5 : 64'd10);
        chk("flush_count", 64'(count), FLUSH_EN ? 64'd5 : 64'd10);
        finish_cycle();
        wb_valid = 1'b1; wb_tag = 4'd7;
        step();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            wb_valid = 1'b1; wb_tag = TAG_W'(i);
            commit_ready = 1'b1;
            step();
        end
        idle_inputs();
        commit_ready = 1'b1;
        repeat (8) step();
        settle();
        chk("flush_drain_count", 64'(count), FLUSH_EN ? 64'd0 : 64'd5);
        finish_cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            if ($urandom_range(0, 99) < 70) set_alloc();
            wb_valid     = ($urandom_range(0, 99) < 60);
            wb_tag       = TAG_W'($urandom);
            commit_ready = ($urandom_range(0, 99) < 60);
            flush_valid  = ($urandom_range(0, 99) < 5);
            flush_tag    = TAG_W'($urandom);
            reset        = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
